// File: rtl/uart_relay_buffer.sv
// Store-and-forward relay between an RX and a TX UART driver, with a
// single-word substitution hook on the way into the queue.
module uart_relay_buffer #(
  parameter int NUM_DATA_BITS = 12,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          rx_new_data,
  input  logic [NUM_DATA_BITS-1:0]      rx_data,
  input  logic                          tx_ready,
  output logic                          tx_start,
  output logic [NUM_DATA_BITS-1:0]      tx_data,
  input  logic                          mitm_enable,
  input  logic [NUM_DATA_BITS-1:0]      match_data,
  input  logic [NUM_DATA_BITS-1:0]      replace_data,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          overflow
);

  // state     | meaning
  // IDLE      | waiting for a queued word and an idle TX driver
  // START     | tx_start pulse, tx_data holds the popped word
  // WAIT_BUSY | waiting for the driver to drop tx_ready
  // WAIT_DONE | waiting for the driver to finish the frame
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  state_t state, state_next;

  logic [NUM_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count_next;
  logic [NUM_DATA_BITS-1:0] wr_word;
  logic                     push_req, push_ok, pop, drop;

  assign push_req = rx_new_data && !flush;
  // Flush suppresses the pop so the queue really ends up empty.
  assign pop      = (state == IDLE) && !fifo_empty && tx_ready && !flush;
  assign push_ok  = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;
  assign wr_word  = (mitm_enable && (rx_data == match_data)) ? replace_data : rx_data;

  always_comb begin
    count_next = fifo_count;
    if (flush)
      count_next = '0;
    else if (push_ok && !pop)
      count_next = fifo_count + (AW+1)'(1);
    else if (pop && !push_ok)
      count_next = fifo_count - (AW+1)'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok)
      mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
      tx_data    <= '0;
    end else begin
      fifo_count <= count_next;
      fifo_empty <= (count_next == '0);
      fifo_full  <= (count_next == FULL_COUNT);
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (drop)
          overflow <= 1'b1;
      end
      if (pop)
        tx_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    case (state)
      IDLE:      if (pop) state_next = START;
      START: begin
        tx_start   = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: if (!tx_ready) state_next = WAIT_DONE;
      WAIT_DONE: if (tx_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_relay_buffer.sv
// Directed bench for uart_relay_buffer with a simple TX driver model that
// logs every word it is told to send.
module tb_uart_relay_buffer;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        rx_new_data;
  logic [11:0] rx_data;
  logic        tx_ready;
  logic        tx_start;
  logic [11:0] tx_data;
  logic        mitm_enable;
  logic [11:0] match_data;
  logic [11:0] replace_data;
  logic        flush;
  logic [4:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic        hold;
  int          busy = 0;
  logic [11:0] rx_log [0:255];
  int          rx_cnt = 0;
  int          base;

  always #5 sys_clk = ~sys_clk;

  uart_relay_buffer #(.NUM_DATA_BITS(12), .FIFO_DEPTH(16)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .rx_new_data  (rx_new_data),
    .rx_data      (rx_data),
    .tx_ready     (tx_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .mitm_enable  (mitm_enable),
    .match_data   (match_data),
    .replace_data (replace_data),
    .flush        (flush),
    .fifo_count   (fifo_count),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .overflow     (overflow)
  );

  // Driver model: busy for two negedges after each tx_start.
  assign tx_ready = !hold && (busy == 0);

  always @(negedge sys_clk) begin
    if (!rst) begin
      busy = 0;
    end else begin
      if (busy > 0) busy = busy - 1;
      if (tx_start) begin
        rx_log[rx_cnt[7:0]] = tx_data;
        rx_cnt = rx_cnt + 1;
        busy = 2;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [11:0] d);
    rx_data     = d;
    rx_new_data = 1'b1;
    @(negedge sys_clk);
    rx_new_data = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    rst          = 1'b0;
    rx_new_data  = 1'b0;
    rx_data      = '0;
    mitm_enable  = 1'b0;
    match_data   = '0;
    replace_data = '0;
    flush        = 1'b0;
    hold         = 1'b0;
    idle_cycles(3);

    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
    idle_cycles(2);

    // single word, minimum latency
    push(12'h4c5);
    check("single_count1", fifo_count, 1);
    check("single_empty0", fifo_empty, 0);
    check("single_start_early", tx_start, 0);
    @(negedge sys_clk);
    check("single_start", tx_start, 1);
    check("single_data", tx_data, 12'h4c5);
    check("single_count0", fifo_count, 0);
    @(negedge sys_clk);
    check("single_start_once", tx_start, 0);
    idle_cycles(10);
    check("single_sent_n", rx_cnt, 1);

    // substitution
    base = rx_cnt;
    mitm_enable  = 1'b1;
    match_data   = 12'hf01;
    replace_data = 12'h0b5;
    push(12'hf01);
    push(12'h51d);
    idle_cycles(20);
    check("sub_n", rx_cnt, base + 2);
    check("sub_w0", rx_log[base], 12'h0b5);
    check("sub_w1", rx_log[base+1], 12'h51d);
    mitm_enable = 1'b0;
    push(12'hf01);
    idle_cycles(10);
    check("sub_off", rx_log[base+2], 12'hf01);

    // substitution decided at push time, not at send time
    base = rx_cnt;
    hold = 1'b1;
    mitm_enable = 1'b1;
    push(12'hf01);
    replace_data = 12'h123;
    match_data   = 12'h000;
    mitm_enable  = 1'b0;
    hold = 1'b0;
    idle_cycles(10);
    check("sub_sampled", rx_log[base], 12'h0b5);

    // back-pressure, overflow, in-order drain
    base = rx_cnt;
    hold = 1'b1;
    for (int i = 1; i <= 16; i++) push(12'(i));
    check("bp_full", fifo_full, 1);
    check("bp_count", fifo_count, 16);
    check("bp_ovf0", overflow, 0);
    push(12'h011);
    check("bp_ovf1", overflow, 1);
    check("bp_count_drop", fifo_count, 16);
    hold = 1'b0;
    idle_cycles(100);
    check("bp_sent_n", rx_cnt, base + 16);
    for (int i = 0; i < 16; i++) check("bp_order", rx_log[base+i], 12'(i + 1));
    check("bp_ovf_sticky", overflow, 1);
    flush = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0;
    check("flush_clr_ovf", overflow, 0);

    // simultaneous push and pop at full
    base = rx_cnt;
    hold = 1'b1;
    for (int i = 1; i <= 16; i++) push(12'h100 + 12'(i));
    check("pp_full", fifo_full, 1);
    hold = 1'b0;
    push(12'h1ff);
    check("pp_count", fifo_count, 16);
    check("pp_ovf", overflow, 0);
    check("pp_start", tx_start, 1);
    idle_cycles(100);
    check("pp_sent_n", rx_cnt, base + 17);
    check("pp_first", rx_log[base], 12'h101);
    check("pp_last", rx_log[base+16], 12'h1ff);

    // flush with a frame in flight
    base = rx_cnt;
    hold = 1'b1;
    for (int i = 1; i <= 6; i++) push(12'h200 + 12'(i));
    hold = 1'b0;
    @(negedge sys_clk);
    check("fl_start", tx_start, 1);
    check("fl_count5", fifo_count, 5);
    flush = 1'b1;
    rx_data = 12'h2ff;
    rx_new_data = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0;
    rx_new_data = 1'b0;
    check("fl_count0", fifo_count, 0);
    check("fl_empty", fifo_empty, 1);
    check("fl_ovf", overflow, 0);
    idle_cycles(30);
    check("fl_sent_n", rx_cnt, base + 1);
    check("fl_sent_w", rx_log[base], 12'h201);

    // reset during WAIT_DONE
    base = rx_cnt;
    push(12'h3a5);
    rx_data = 12'h3a6;
    rx_new_data = 1'b1;
    @(negedge sys_clk);
    rx_new_data = 1'b0;
    idle_cycles(2);
    check("mr_count_pre", fifo_count, 1);
    #1 rst = 1'b0;
    #1;
    check("mr_tx_start", tx_start, 0);
    check("mr_tx_data", tx_data, 0);
    check("mr_count", fifo_count, 0);
    check("mr_empty", fifo_empty, 1);
    check("mr_full", fifo_full, 0);
    check("mr_ovf", overflow, 0);
    @(negedge sys_clk);
    rst = 1'b1;
    idle_cycles(20);
    check("mr_lost", rx_cnt, base + 1);
    push(12'h3c3);
    idle_cycles(10);
    check("mr_after_n", rx_cnt, base + 2);
    check("mr_after_w", rx_log[base+1], 12'h3c3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
